// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one req/ack FIFO push port between NREQ requesters.
// It registers the winning item, holds it until push_ack, and flags grants that wait too long.
module fifo_push_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int TMO   = 15,
  parameter int TW    = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       ack,
  output logic                  push_req,
  output logic [WIDTH-1:0]      push_data,
  input  logic                  push_ack,
  input  logic                  full,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout
);

  // Handshake: push_req/push_data stay fixed from grant until the cycle push_ack
  // is seen with push_req high; that cycle is the transfer and ack[grant_id] pulses.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [IW:0]    NREQ_W   = (IW+1)'(NREQ);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NREQ - 1);
  localparam logic [TW-1:0]  TMO_M1   = TW'(TMO - 1);
  localparam logic [TW-1:0]  TMAX     = {TW{1'b1}};

  state_t           state_q, state_d;
  logic             push_req_q, push_req_d;
  logic [WIDTH-1:0] push_data_q, push_data_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW:0]      cand;

  // Scan from ptr upward, wrapping by compare so non-power-of-2 NREQ works.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    push_req_d  = push_req_q;
    push_data_d = push_data_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !full) begin
          state_d     = ISSUE;
          push_req_d  = 1'b1;
          push_data_d = data_in[win_idx*WIDTH +: WIDTH];
          grant_id_d  = win_idx;
          timer_d     = '0;
        end
      end
      ISSUE: begin
        if (push_ack) begin
          state_d    = IDLE;
          push_req_d = 1'b0;
          ptr_d      = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
        end else begin
          if (timer_q != TMAX) timer_d = timer_q + 1'b1;
          // The timer passes TMO-1 -> TMO only once per grant, so this pulses once.
          if (timer_q == TMO_M1) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      push_req_q  <= 1'b0;
      push_data_q <= '0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      push_req_q  <= push_req_d;
      push_data_q <= push_data_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    ack = '0;
    if (push_req_q && push_ack) ack[grant_id_q] = 1'b1;
  end

  assign push_req  = push_req_q;
  assign push_data = push_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = push_req_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: a 4-requester and a 3-requester instance driven by directed
// steps and random traffic, checked against a transaction-level reference model.
module tb_fifo_push_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] req_v  [2];
  logic [7:0] din    [2][4];
  logic       full_v [2];
  logic       pack_v [2];

  logic [31:0] din0;
  logic [23:0] din1;
  logic [3:0]  ack0;
  logic [2:0]  ack1;
  logic        pr0, pr1, b0, b1, t0, t1;
  logic [7:0]  pd0, pd1;
  logic [1:0]  g0, g1;

  always #5 clk = ~clk;

  always_comb begin
    din0 = {din[0][3], din[0][2], din[0][1], din[0][0]};
    din1 = {din[1][2], din[1][1], din[1][0]};
  end

  fifo_push_arbiter #(.NREQ(4), .WIDTH(8), .TMO(15), .TW(4)) u0 (
    .clk(clk), .resetn(resetn), .req(req_v[0]), .data_in(din0), .ack(ack0),
    .push_req(pr0), .push_data(pd0), .push_ack(pack_v[0]), .full(full_v[0]),
    .grant_id(g0), .busy(b0), .timeout(t0)
  );

  fifo_push_arbiter #(.NREQ(3), .WIDTH(8), .TMO(5), .TW(4)) u1 (
    .clk(clk), .resetn(resetn), .req(req_v[1][2:0]), .data_in(din1), .ack(ack1),
    .push_req(pr1), .push_data(pd1), .push_ack(pack_v[1]), .full(full_v[1]),
    .grant_id(g1), .busy(b1), .timeout(t1)
  );

  // Reference model: one outstanding push per instance, described as a transaction.
  bit         m_busy [2];
  int         m_ptr  [2];
  int         m_gid  [2];
  int         m_cyc  [2];
  logic [7:0] m_data [2];
  logic [3:0] exp_ack[2];

  int n_vec = 0;
  int n_err = 0;

  function automatic int nreq_of(input int d);
    return (d != 0) ? 3 : 4;
  endfunction

  function automatic int tmo_of(input int d);
    return (d != 0) ? 5 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_busy[d]  = 1'b0;
    m_ptr[d]   = 0;
    m_gid[d]   = 0;
    m_cyc[d]   = 0;
    m_data[d]  = '0;
    exp_ack[d] = '0;
  endtask

  task automatic check_dut(input int d);
    logic [3:0] ea;
    logic       eto;
    ea = '0;
    if (m_busy[d] && pack_v[d]) ea[m_gid[d]] = 1'b1;
    eto = m_busy[d] && (m_cyc[d] == tmo_of(d) + 1);
    exp_ack[d] = ea;
    chk($sformatf("u%0d.push_req", d),  (d != 0) ? pr1 : pr0, 32'(m_busy[d]));
    chk($sformatf("u%0d.busy", d),      (d != 0) ? b1 : b0, 32'(m_busy[d]));
    chk($sformatf("u%0d.push_data", d), (d != 0) ? pd1 : pd0, 32'(m_data[d]));
    chk($sformatf("u%0d.grant_id", d),  (d != 0) ? g1 : g0, 32'(m_gid[d]));
    chk($sformatf("u%0d.timeout", d),   (d != 0) ? t1 : t0, 32'(eto));
    chk($sformatf("u%0d.ack", d),       (d != 0) ? {1'b0, ack1} : ack0, 32'(ea));
  endtask

  task automatic model_step(input int d);
    int  n;
    int  idx;
    bit  found;
    n = nreq_of(d);
    if (m_busy[d]) begin
      if (pack_v[d]) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = (m_gid[d] + 1) % n;
      end else begin
        m_cyc[d]++;
      end
    end else if (!full_v[d]) begin
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        idx = (m_ptr[d] + k) % n;
        if (!found && req_v[d][idx]) begin
          found     = 1'b1;
          m_busy[d] = 1'b1;
          m_gid[d]  = idx;
          m_data[d] = din[d][idx];
          m_cyc[d]  = 1;
        end
      end
    end
  endtask

  // Called in the low phase with inputs already set: check, advance model, take one edge.
  task automatic tick();
    #1;
    check_dut(0);
    check_dut(1);
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_random(input int p_ack, input int p_full);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nreq_of(d); i++) begin
        if (exp_ack[d][i]) begin
          if ($urandom_range(0, 1) == 0) req_v[d][i] = 1'b0;
          else din[d][i] = 8'($urandom);
        end else if (!req_v[d][i] && $urandom_range(0, 3) == 0) begin
          req_v[d][i] = 1'b1;
          din[d][i]   = 8'($urandom);
        end
      end
      pack_v[d] = ($urandom_range(0, 99) < p_ack);
      full_v[d] = ($urandom_range(0, 99) < p_full);
    end
  endtask

  int       to_cnt;
  int       to_at;
  int       rr_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d]  = '0;
      full_v[d] = 1'b0;
      pack_v[d] = 1'b0;
      for (int i = 0; i < 4; i++) din[d][i] = '0;
      model_reset(d);
    end

    // Values held during reset
    #12;
    chk("rst.push_req", pr0, 0);
    chk("rst.push_data", pd0, 0);
    chk("rst.grant_id", g0, 0);
    chk("rst.timeout", t0, 0);
    chk("rst.ack", ack0, 0);
    chk("rst.u1.push_req", pr1, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Round robin with every requester asking and instant push_ack
    req_v[0]  = 4'b1111;
    pack_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) din[0][i] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr.push_req", pr0, 1);
      chk("rr.grant", g0, rr_order[k]);
      tick();
      chk("rr.gap", pr0, 0);
    end
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();

    // Single request, push_ack two cycles after push_req
    req_v[0]  = 4'b0100;
    din[0][2] = 8'hA5;
    tick();
    chk("single.push_data", pd0, 8'hA5);
    chk("single.grant_id", g0, 2);
    tick();
    tick();
    pack_v[0] = 1'b1;
    #1;
    chk("single.ack", ack0, 4'b0100);
    tick();
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();
    req_v[0]  = 4'b1011;
    tick();
    chk("single.next_ptr", g0, 3);
    pack_v[0] = 1'b1;
    tick();
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();

    // Request waits while full, then is granted on the first non-full cycle
    req_v[0]  = 4'b0001;
    din[0][0] = 8'h3C;
    full_v[0] = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("full.held_off", pr0, 0);
    full_v[0] = 1'b0;
    tick();
    chk("full.granted", pr0, 1);
    chk("full.data", pd0, 8'h3C);
    pack_v[0] = 1'b1;
    tick();
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();

    // Timeout: grant left without push_ack for 20 ISSUE cycles
    req_v[0]  = 4'b0010;
    din[0][1] = 8'h5A;
    tick();
    to_cnt = 0;
    to_at  = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (t0) begin
        to_cnt++;
        to_at = c;
      end
      chk("tmo.push_data", pd0, 8'h5A);
      tick();
    end
    chk("tmo.pulse_count", to_cnt, 1);
    chk("tmo.pulse_cycle", to_at, 16);
    pack_v[0] = 1'b1;
    #1;
    chk("tmo.late_ack", ack0, 4'b0010);
    tick();
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();

    // Wrap on the 3-requester instance: move ptr to 2, then 3'b011
    req_v[1]  = 4'b0010;
    din[1][1] = 8'h21;
    pack_v[1] = 1'b1;
    tick();
    tick();
    req_v[1]  = 4'b0011;
    din[1][0] = 8'h20;
    tick();
    chk("wrap.grant0", g1, 0);
    tick();
    tick();
    chk("wrap.grant1", g1, 1);
    tick();
    req_v[1]  = '0;
    pack_v[1] = 1'b0;
    tick();

    // Asynchronous reset while requester 3 is being issued
    req_v[0]  = 4'b1000;
    din[0][3] = 8'hC3;
    tick();
    chk("areset.pre_grant", g0, 3);
    pack_v[0] = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("areset.push_req", pr0, 0);
    chk("areset.ack", ack0, 0);
    chk("areset.grant_id", g0, 0);
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(negedge clk);
    resetn    = 1'b1;
    pack_v[0] = 1'b0;
    tick();
    chk("areset.regrant", g0, 3);
    pack_v[0] = 1'b1;
    tick();
    req_v[0]  = '0;
    pack_v[0] = 1'b0;
    tick();

    // Random traffic: quick acks, then slow acks that provoke timeouts
    for (int c = 0; c < 1500; c++) begin
      drive_random(60, 20);
      tick();
    end
    for (int c = 0; c < 1500; c++) begin
      drive_random(4, 10);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the single push port of the team's req/ack FIFO between NREQ upstream requesters using round-robin arbitration.
- Registers the winner's data and drives push_req/push_data to the FIFO.
- Holds push_req and push_data stable until push_ack, then returns ack to the winning requester.
- Flags a grant that waits too long for push_ack.

Parameters:
NREQ, 4, number of requesters (2..16, need not be a power of 2)
WIDTH, 8, data width per requester and of the FIFO push port
TMO, 15, cycles in ISSUE before the timeout pulse (1..2^TW-1)
TW, 4, timer width

Ports:
clk  in  1  clock
resetn  in  1  reset
req  in  NREQ  per-requester request, held until matching ack
data_in  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH], stable while req[i] high
ack  out  NREQ  one-cycle acceptance pulse to requester
push_req  out  1  FIFO push request, registered
push_data  out  WIDTH  FIFO push data, registered
push_ack  in  1  FIFO push acknowledge
full  in  1  FIFO full flag
grant_id  out  $clog2(NREQ)  index of the current or last winner
busy  out  1  high in ISSUE (equals push_req)
timeout  out  1  one-cycle pulse when a grant has waited TMO cycles

Behaviour:
- Reset: resetn asynchronous, active-low; clock clk.
- Values during reset: state=IDLE, push_req=0, push_data=0, grant_id=0, rr pointer=0, timer=0, timeout=0, ack=0.
- Reset mid-ISSUE drops push_req immediately. No ack is issued for the aborted grant.
- FSM states: IDLE and ISSUE.
- IDLE, when |req && !full:
  - Winner = first i with req[i] set, scanning ptr, ptr+1, ... and wrapping modulo NREQ.
  - Next edge: push_data<=data_in[winner], grant_id<=winner, push_req<=1, timer<=0, state<=ISSUE.
- IDLE, when full=1 or req=0: stay in IDLE with no grant. A request arriving while full is not lost; it is granted on the first cycle full=0.
- ISSUE:
  - push_req stays 1; push_data and grant_id do not change.
  - req changes by other requesters are ignored.
  - full is ignored, since the FIFO withholds push_ack while full.
- Ack: ack[grant_id] = push_req && push_ack, combinational, same cycle as the FIFO handshake. ack is otherwise 0, and at most one bit is ever set.
- On the handshake cycle, next edge: push_req<=0, ptr<=(grant_id+1) mod NREQ, state<=IDLE.
- Throughput is at most one push per 2 cycles; there is no back-to-back grant.
- The requester must drop req[i] the cycle after ack[i] or present a new item. A req still high after ack is treated as a new request.
- Latency: req asserted in cycle N with IDLE and !full gives push_req=1 in cycle N+1. The earliest ack is in cycle N+1.
- Timer:
  - Increments every ISSUE cycle without push_ack and saturates at 2^TW-1.
  - timeout=1 for exactly one cycle, the cycle after the timer reaches TMO. This happens at most once per grant.
  - timeout does not drop push_req; the stability rule has priority.
  - The timer clears when a new grant is entered.
- push_ack while push_req=0 is ignored: no ack, no state change.
- Widths: ptr and grant_id are $clog2(NREQ) bits. Wrap from NREQ-1 to 0 uses an explicit compare, not overflow.

Test Plan:
- Single request: req=4'b0100, data_in[2]=8'hA5, full=0, push_ack returned 2 cycles after push_req -> push_req held for 3 cycles, push_data=8'hA5 and grant_id=2 stable throughout, ack=4'b0100 on the push_ack cycle only, ptr becomes 3.
- Round-robin fairness: req=4'b1111 held, push_ack=1 whenever push_req=1 -> grant order 0,1,2,3,0, one push every 2 cycles, never the same index twice in a row.
- Wrap with NREQ=3: ptr=2, req=3'b011 -> grant 0, ptr becomes 1. Next grant 1, ptr wraps to 2. The grant never selects an index outside 0..2.
- Full gating: full=1 with req=4'b0001 for 10 cycles -> push_req stays 0 and ack stays 0. full drops at cycle 10 -> push_req=1 at cycle 11 with data_in[0].
- Timeout: TMO=15, push_ack held 0 after a grant -> timeout pulses exactly once at the 16th ISSUE cycle. push_req and push_data remain stable; a later push_ack completes normally with ack.
- Async reset mid-ISSUE: resetn low while push_req=1, grant_id=3 -> push_req=0 and ptr=0 immediately. After release with req=4'b1000, grant_id=3 is issued again and no stale ack appears.
